// File: rtl/i2c_write_arbiter_pkg.sv
// Shared definitions for the i2c_com write arbiter: FSM encodings, word layout and helpers.
package i2c_write_arbiter_pkg;

  localparam int I2C_WORD_W = 32;
  localparam int ID_W       = 3;

  localparam logic [7:0] OV5640_DEV_ADDR = 8'h78;

  localparam int DEV_ADDR_LSB = 24;
  localparam int REG_ADDR_LSB = 8;
  localparam int DATA_LSB     = 0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef struct packed {
    logic [7:0]  dev_addr;
    logic [15:0] reg_addr;
    logic [7:0]  data;
  } i2c_word_t;

  function automatic logic [I2C_WORD_W-1:0] pack_word(input logic [7:0]  dev_addr,
                                                      input logic [15:0] reg_addr,
                                                      input logic [7:0]  data);
    i2c_word_t w;
    w.dev_addr = dev_addr;
    w.reg_addr = reg_addr;
    w.data     = data;
    return w;
  endfunction

endpackage

// File: rtl/i2c_write_arbiter_if.sv
// Bundle of requester-side and engine-side signals around the write arbiter.
interface i2c_write_arbiter_if
  import i2c_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [I2C_WORD_W*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]            req_done;
  logic [NUM_REQ-1:0]            req_err;
  logic                          busy;
  logic [ID_W-1:0]               grant_id;
  logic [I2C_WORD_W-1:0]         i2c_data;
  logic                          start;
  logic                          tr_end;
  logic                          ack;

  // master is the arbiter; slave is the requesters plus the i2c_com engine
  modport master (
    input  req_valid, req_data, tr_end, ack,
    output req_done, req_err, busy, grant_id, i2c_data, start
  );

  modport slave (
    output req_valid, req_data, tr_end, ack,
    input  req_done, req_err, busy, grant_id, i2c_data, start
  );

endinterface

// File: rtl/i2c_write_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first valid requester after rr_ptr, modulo NUM_REQ.
module i2c_rr_pick
  import i2c_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic               any,
  output logic [ID_W-1:0]    winner
);

  localparam int PW = ID_W + 1;

  logic [(2**ID_W)-1:0] valid_pad;
  logic [PW-1:0]        pos;
  logic                 found;

  assign any = |req_valid;

  // Walk the requesters in order rr_ptr+1, rr_ptr+2, ...; the first hit wins.
  always_comb begin
    valid_pad = (2**ID_W)'(req_valid);
    winner    = '0;
    found     = 1'b0;
    pos       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      pos = {1'b0, rr_ptr} + PW'(k);
      if (pos >= PW'(NUM_REQ)) begin
        pos = pos - PW'(NUM_REQ);
      end
      if (!found && valid_pad[pos[ID_W-1:0]]) begin
        winner = pos[ID_W-1:0];
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_write_arbiter.sv
// Round-robin arbiter sharing the single i2c_com write engine between NUM_REQ requesters.
// One 32-bit word per grant; each transfer reports NACK or timeout on req_err.
module i2c_write_arbiter
  import i2c_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 4000,
  parameter int CNT_W       = 12
) (
  input logic                 clock_i2c,
  input logic                 camera_rst,
  i2c_write_arbiter_if.master bus
);

  logic [1:0]            state;
  logic [ID_W-1:0]       rr_ptr;
  logic [ID_W-1:0]       grant_id;
  logic [CNT_W-1:0]      cnt;
  logic [I2C_WORD_W-1:0] i2c_data;
  logic                  start;
  logic                  busy;
  logic [NUM_REQ-1:0]    req_done;
  logic [NUM_REQ-1:0]    req_err;
  logic                  any;
  logic [ID_W-1:0]       winner;
  logic [I2C_WORD_W-1:0] win_word;
  logic [NUM_REQ-1:0]    grant_oh;

  i2c_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_valid (bus.req_valid),
    .rr_ptr    (rr_ptr),
    .any       (any),
    .winner    (winner)
  );

  assign grant_oh = NUM_REQ'(1) << grant_id;

  always_comb begin
    win_word = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) begin
        win_word = bus.req_data[I2C_WORD_W*i +: I2C_WORD_W];
      end
    end
  end

  // A stale tr_end from the previous transfer blocks new grants until it drops.
  always_ff @(posedge clock_i2c or posedge camera_rst) begin
    if (camera_rst) begin
      state    <= ST_IDLE;
      rr_ptr   <= ID_W'(NUM_REQ - 1);
      cnt      <= '0;
      i2c_data <= '0;
      start    <= 1'b0;
      busy     <= 1'b0;
      grant_id <= '0;
      req_done <= '0;
      req_err  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any && !bus.tr_end) begin
            i2c_data <= win_word;
            start    <= 1'b1;
            busy     <= 1'b1;
            grant_id <= winner;
            rr_ptr   <= winner;
            cnt      <= '0;
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.tr_end) begin
            start    <= 1'b0;
            req_done <= grant_oh;
            req_err  <= bus.ack ? grant_oh : '0;
            state    <= ST_DONE;
          end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            start    <= 1'b0;
            req_done <= grant_oh;
            req_err  <= grant_oh;
            state    <= ST_DONE;
          end else if (cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          req_done <= '0;
          req_err  <= '0;
          busy     <= 1'b0;
          state    <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.i2c_data = i2c_data;
  assign bus.start    = start;
  assign bus.busy     = busy;
  assign bus.grant_id = grant_id;
  assign bus.req_done = req_done;
  assign bus.req_err  = req_err;

endmodule
